lsq_mem_responder: RTL and testbench

LSQ_MEM_RESPONDER -- requirements
Module: lsq_mem_responder

---
 rtl/lsq_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_lsq_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_mem_responder.sv
// lsq_mem_responder
//
// Word-addressed data memory that answers load/store requests issued by a
// load/store queue. One request per cycle is accepted without backpressure.
// The memory access happens in the acceptance cycle. The result then travels
// through a LATENCY-deep valid/data shift pipeline, so responses come back
// in acceptance order exactly LATENCY cycles later.
//
// Parameters
//   DEPTH_WORDS : memory size in 32-bit words (default 256)
//   LATENCY     : request-to-response cycles, legal range 1..4 (default 2)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset; clears pipeline and memory
//   reqValid   in   request present this cycle
//   pcIn       in   PC tag of the load/store
//   addressIn  in   byte address
//   loadStore  in   0 load, 1 store
//   sizeIn     in   0 word, 1 byte
//   swDataIn   in   store data (byte store uses [7:0])
//   completeIn in   load already satisfied by the LSQ (bypass build only)
//   lwDataIn   in   LSQ-forwarded load data (bypass build only)
//   flush      in   discard every in-flight response
//   respValid  out  one-cycle response pulse
//   respPc     out  PC tag of the completing request
//   respData   out  load result, 0 for stores and errors
//   respStore  out  response is a store acknowledge
//   respErr    out  misaligned word access or out-of-range address
//
// Build option
//   LSQ_BYPASS_EN : when defined, a load with completeIn=1 skips the memory
//                   read and returns lwDataIn. When undefined, completeIn
//                   and lwDataIn are ignored.

module lsq_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    input  logic [31:0] pcIn,
    input  logic [31:0] addressIn,
    input  logic        loadStore,
    input  logic        sizeIn,
    input  logic [31:0] swDataIn,
    input  logic        completeIn,
    input  logic [31:0] lwDataIn,
    input  logic        flush,
    output logic        respValid,
    output logic [31:0] respPc,
    output logic [31:0] respData,
    output logic        respStore,
    output logic        respErr
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef struct packed {
        logic        store;
        logic        err;
        logic [31:0] pc;
        logic [31:0] data;
    } resp_t;

    logic [31:0]        mem [DEPTH_WORDS];

    logic [29:0]        word_num;
    logic [AW-1:0]      idx;
    logic [1:0]         lane;
    logic               in_range;
    logic               misaligned;
    logic               acc_err;
    logic               use_fwd;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [31:0]        ld_value;
    resp_t              new_resp;

    resp_t              pipe_d [LATENCY];
    logic [LATENCY-1:0] pipe_v;

    assign word_num = addressIn[31:2];
    assign idx      = addressIn[AW+1:2];
    assign lane     = addressIn[1:0];

    // The range check uses the full word number so that addresses above the
    // memory never alias onto a low word through the truncated index.
    assign in_range   = ({2'b00, word_num} < 32'(DEPTH_WORDS));
    assign misaligned = ~sizeIn & (lane != 2'b00);
    assign acc_err    = misaligned | ~in_range;

`ifdef LSQ_BYPASS_EN
    assign use_fwd = ~loadStore & completeIn;
`else
    logic unused_fwd;
    assign use_fwd    = 1'b0;
    assign unused_fwd = ^{completeIn, lwDataIn};
`endif

    // Read reflects every store accepted on earlier edges, which gives
    // write-before-read ordering for a load issued right after a store.
    assign rd_word = in_range ? mem[idx] : 32'h0;

    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    assign ld_value = sizeIn ? {{24{rd_byte[7]}}, rd_byte} : rd_word;

    always_comb begin
        new_resp       = '0;
        new_resp.pc    = pcIn;
        new_resp.store = loadStore;
        if (loadStore) begin
            new_resp.err  = acc_err;
            new_resp.data = 32'h0;
        end else if (use_fwd) begin
            new_resp.err  = 1'b0;
            new_resp.data = lwDataIn;
        end else if (acc_err) begin
            new_resp.err  = 1'b1;
            new_resp.data = 32'h0;
        end else begin
            new_resp.err  = 1'b0;
            new_resp.data = ld_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_d[i] <= '0;
            end
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            // A request arriving together with flush is still accepted; only
            // the older stages are discarded.
            pipe_v[0] <= reqValid;
            pipe_d[0] <= new_resp;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1] & ~flush;
                pipe_d[i] <= pipe_d[i-1];
            end

            if (reqValid && loadStore && !acc_err) begin
                if (!sizeIn) begin
                    mem[idx] <= swDataIn;
                end else begin
                    case (lane)
                        2'd0:    mem[idx][7:0]   <= swDataIn[7:0];
                        2'd1:    mem[idx][15:8]  <= swDataIn[7:0];
                        2'd2:    mem[idx][23:16] <= swDataIn[7:0];
                        default: mem[idx][31:24] <= swDataIn[7:0];
                    endcase
                end
            end
        end
    end

    // The last stage is masked by flush and rst in the same cycle, so a
    // response sitting at the output when either arrives is never emitted.
    assign respValid = pipe_v[LATENCY-1] & ~flush & ~rst;
    assign respPc    = respValid ? pipe_d[LATENCY-1].pc    : 32'h0;
    assign respData  = respValid ? pipe_d[LATENCY-1].data  : 32'h0;
    assign respStore = respValid ? pipe_d[LATENCY-1].store : 1'b0;
    assign respErr   = respValid ? pipe_d[LATENCY-1].err   : 1'b0;

endmodule

// File: tb/tb_lsq_mem_responder.sv
module tb_lsq_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic [31:0] pcIn;
    logic [31:0] addressIn;
    logic        loadStore;
    logic        sizeIn;
    logic [31:0] swDataIn;
    logic        completeIn;
    logic [31:0] lwDataIn;
    logic        flush;
    logic        respValid;
    logic [31:0] respPc;
    logic [31:0] respData;
    logic        respStore;
    logic        respErr;

    int errors = 0;
    int checks = 0;

`ifdef LSQ_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'h0000_0055;
`else
    localparam logic [31:0] BYP_EXP = 32'h0000_0099;
`endif

    always #5 clk = ~clk;

    lsq_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .reqValid   (reqValid),
        .pcIn       (pcIn),
        .addressIn  (addressIn),
        .loadStore  (loadStore),
        .sizeIn     (sizeIn),
        .swDataIn   (swDataIn),
        .completeIn (completeIn),
        .lwDataIn   (lwDataIn),
        .flush      (flush),
        .respValid  (respValid),
        .respPc     (respPc),
        .respData   (respData),
        .respStore  (respStore),
        .respErr    (respErr)
    );

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic set_req(input logic ls, input logic sz, input logic cmp,
                           input logic [31:0] pc, input logic [31:0] addr,
                           input logic [31:0] sw, input logic [31:0] lwd);
        reqValid   = 1'b1;
        loadStore  = ls;
        sizeIn     = sz;
        completeIn = cmp;
        pcIn       = pc;
        addressIn  = addr;
        swDataIn   = sw;
        lwDataIn   = lwd;
    endtask

    task automatic idle();
        reqValid   = 1'b0;
        loadStore  = 1'b0;
        sizeIn     = 1'b0;
        completeIn = 1'b0;
        pcIn       = 32'h0;
        addressIn  = 32'h0;
        swDataIn   = 32'h0;
        lwDataIn   = 32'h0;
    endtask

    task automatic check(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] data, input logic st, input logic er);
        logic [66:0] obs;
        logic [66:0] expv;
        #1;
        obs  = {respValid, respPc, respData, respStore, respErr};
        expv = {v, pc, data, st, er};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed v=%0b pc=%h data=%h st=%0b err=%0b, expected v=%0b pc=%h data=%h st=%0b err=%0b",
                   tag, respValid, respPc, respData, respStore, respErr, v, pc, data, st, er);
        end
    endtask

    // Issue one request, then expect its response two cycles later and
    // nothing the cycle after that.
    task automatic txn(input string tag, input logic ls, input logic sz, input logic cmp,
                       input logic [31:0] pc, input logic [31:0] addr,
                       input logic [31:0] sw, input logic [31:0] lwd,
                       input logic [31:0] exp_data, input logic exp_err);
        set_req(ls, sz, cmp, pc, addr, sw, lwd);
        nxt();
        idle();
        nxt();
        check(tag, 1'b1, pc, exp_data, ls, exp_err);
        nxt();
        check({tag, "_end"}, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        idle();
        flush = 1'b0;
        rst   = 1'b1;
        // Store presented during reset must be ignored.
        set_req(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 32'hAAAA_5555, 32'h0);
        nxt();
        check("rst_out0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        check("rst_out1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        idle();
        nxt();
        check("rst_out2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        check("rst_out3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // SW then LW to the same word on the next cycle.
        set_req(1'b1, 1'b0, 1'b0, 32'h4, 32'h10, 32'hDEAD_BEEF, 32'h0);
        nxt();
        set_req(1'b0, 1'b0, 1'b0, 32'h8, 32'h10, 32'h0, 32'h0);
        check("sw_lat1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        idle();
        check("sw_ack", 1'b1, 32'h4, 32'h0, 1'b1, 1'b0);
        nxt();
        check("lw_after_sw", 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0, 1'b0);
        nxt();
        check("pulse_end", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();

        // Reset-ignored store must not have touched word 0.
        txn("lw_word0", 1'b0, 1'b0, 1'b0, 32'h0C, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Byte store into a word, sign-extended byte loads.
        txn("sw_20",  1'b1, 1'b0, 1'b0, 32'h10, 32'h20, 32'h1122_3344, 32'h0, 32'h0, 1'b0);
        txn("sb_21",  1'b1, 1'b1, 1'b0, 32'h14, 32'h21, 32'hFFFF_FF80, 32'h0, 32'h0, 1'b0);
        txn("lb_21",  1'b0, 1'b1, 1'b0, 32'h18, 32'h21, 32'h0, 32'h0, 32'hFFFF_FF80, 1'b0);
        txn("lw_20",  1'b0, 1'b0, 1'b0, 32'h1C, 32'h20, 32'h0, 32'h0, 32'h1122_8044, 1'b0);
        txn("lb_23",  1'b0, 1'b1, 1'b0, 32'h20, 32'h23, 32'h0, 32'h0, 32'h0000_0011, 1'b0);

        // Error cases leave memory untouched.
        txn("lw_mis",  1'b0, 1'b0, 1'b0, 32'h24, 32'h22, 32'h0, 32'h0, 32'h0, 1'b1);
        txn("sw_oor",  1'b1, 1'b0, 1'b0, 32'h28, 32'h400, 32'h1234_5678, 32'h0, 32'h0, 1'b1);
        txn("lw_w0b",  1'b0, 1'b0, 1'b0, 32'h2C, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        txn("sw_mis",  1'b1, 1'b0, 1'b0, 32'h30, 32'h12, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);
        txn("lw_10b",  1'b0, 1'b0, 1'b0, 32'h34, 32'h10, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        txn("lw_oor",  1'b0, 1'b0, 1'b0, 32'h38, 32'h400, 32'h0, 32'h0, 32'h0, 1'b1);

        // Last in-range word.
        txn("sw_last", 1'b1, 1'b0, 1'b0, 32'h3C, 32'h3FC, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b0);
        txn("lw_last", 1'b0, 1'b0, 1'b0, 32'h40, 32'h3FC, 32'h0, 32'h0, 32'hCAFE_F00D, 1'b0);

        // LSQ-forwarded load data.
        txn("sw_30",   1'b1, 1'b0, 1'b0, 32'h44, 32'h30, 32'h0000_0099, 32'h0, 32'h0, 1'b0);
        txn("lw_byp",  1'b0, 1'b0, 1'b1, 32'h48, 32'h30, 32'h0, 32'h55, BYP_EXP, 1'b0);

        // Three back-to-back loads drained by flush.
        set_req(1'b0, 1'b0, 1'b0, 32'h100, 32'h10, 32'h0, 32'h0);
        nxt();
        set_req(1'b0, 1'b0, 1'b0, 32'h104, 32'h10, 32'h0, 32'h0);
        check("fl_a", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        set_req(1'b0, 1'b0, 1'b0, 32'h108, 32'h10, 32'h0, 32'h0);
        flush = 1'b1;
        check("fl_b", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        idle();
        check("fl_c", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        flush = 1'b0;
        check("fl_d", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        check("fl_e", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        check("fl_f", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();

        // A request presented together with flush is still accepted.
        set_req(1'b0, 1'b0, 1'b0, 32'h200, 32'h10, 32'h0, 32'h0);
        flush = 1'b1;
        check("flacc_a", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        idle();
        flush = 1'b0;
        check("flacc_b", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        check("flacc_resp", 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 1'b0);
        nxt();
        txn("after_flush", 1'b0, 1'b0, 1'b0, 32'h204, 32'h20, 32'h0, 32'h0, 32'h1122_8044, 1'b0);

        // Reset with two requests in flight.
        set_req(1'b1, 1'b0, 1'b0, 32'h300, 32'h10, 32'h0BAD_F00D, 32'h0);
        nxt();
        set_req(1'b0, 1'b0, 1'b0, 32'h304, 32'h20, 32'h0, 32'h0);
        nxt();
        idle();
        rst = 1'b1;
        check("rstmid_a", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        check("rstmid_b", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        rst = 1'b0;
        check("rstmid_c", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        check("rstmid_d", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        nxt();
        txn("rst_lw10", 1'b0, 1'b0, 1'b0, 32'h308, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0);
        txn("rst_lw20", 1'b0, 1'b0, 1'b0, 32'h30C, 32'h20, 32'h0, 32'h0, 32'h0, 1'b0);
        txn("rst_lwlast", 1'b0, 1'b0, 1'b0, 32'h310, 32'h3FC, 32'h0, 32'h0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
